// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: debounced two-button, six-digit pattern entry feeding the HEX rotator.
// Define ENTRY_TIMEOUT_EN to abort an idle entry after TIMEOUT_CYCLES cycles.
module digit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        key_enter_n,
    input  logic        key_clear_n,
    input  logic [3:0]  digit_in,
    output logic [23:0] pattern,
    output logic        pattern_valid,
    output logic [23:0] edit_view,
    output logic [2:0]  cursor,
    output logic        busy,
    output logic        entry_err
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, ENTRY = 2'd1, LOAD = 2'd2;

    logic [1:0] state;
    logic [23:0] work;
    logic [1:0] keys_n, press;
    logic ent_ev, clr_ev, tmo, digit_ok;
    logic [4:0] sh;

    assign keys_n = {key_clear_n, key_enter_n};
    assign ent_ev = press[0];
    assign clr_ev = press[1];

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0] sync;
        logic [DW-1:0] cnt;
        logic lvl, lvl_d, ev;
        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                sync <= 2'b11;
                cnt <= '0;
                lvl <= 1'b1;
                lvl_d <= 1'b1;
                ev <= 1'b0;
            end else begin
                sync <= {sync[0], keys_n[b]};
                cnt <= (sync[1] == lvl || cnt == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt + DW'(1);
                if (sync[1] != lvl && cnt == DW'(DEBOUNCE_CYCLES - 1))
                    lvl <= sync[1];
                lvl_d <= lvl;
                ev <= lvl_d & ~lvl;
            end
        end
        assign press[b] = ev;
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N || ent_ev || clr_ev || state != ENTRY)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end
    assign tmo = (state == ENTRY) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    assign digit_ok = (digit_in <= 4'd9) || (digit_in == 4'hF);
    assign sh = 5'd20 - {cursor, 2'b00};
    assign busy = (state == ENTRY);

    // Live view shows the switch value at the cursor before it is committed
    always_comb begin
        edit_view = busy ? work : pattern;
        if (busy)
            edit_view[sh +: 4] = digit_in;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state <= IDLE;
            work <= 24'hFFFFFF;
            cursor <= 3'd0;
            pattern <= 24'h085FFF;
            pattern_valid <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            pattern_valid <= 1'b0;
            entry_err <= 1'b0;
            if (clr_ev || tmo) begin
                work <= 24'hFFFFFF;
                cursor <= 3'd0;
                state <= IDLE;
            end else if (state == LOAD) begin
                pattern <= work;
                pattern_valid <= 1'b1;
                work <= 24'hFFFFFF;
                cursor <= 3'd0;
                state <= IDLE;
            end else if (ent_ev && !digit_ok) begin
                entry_err <= 1'b1;
            end else if (ent_ev && state == IDLE) begin
                work <= {digit_in, 20'hFFFFF};
                cursor <= 3'd1;
                state <= ENTRY;
            end else if (ent_ev) begin
                work[sh +: 4] <= digit_in;
                cursor <= (cursor == 3'd5) ? cursor : cursor + 3'd1;
                state <= (cursor == 3'd5) ? LOAD : ENTRY;
            end
        end
    end
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl: directed and random press sequences against a digit-queue model.
module tb_digit_entry_ctrl;
    logic CLOCK_50 = 1'b0, RESET_N = 1'b0, key_enter_n = 1'b1, key_clear_n = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic [23:0] pattern, edit_view;
    logic [2:0] cursor;
    logic pattern_valid, busy, entry_err;
    int checks = 0, errors = 0, pv_cnt = 0, err_cnt = 0, exp_pv = 0, exp_err = 0;
    logic [3:0] q[$];
    logic [23:0] exp_pat = 24'h085FFF;

    digit_entry_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_enter_n(key_enter_n),
        .key_clear_n(key_clear_n), .digit_in(digit_in), .pattern(pattern),
        .pattern_valid(pattern_valid), .edit_view(edit_view), .cursor(cursor),
        .busy(busy), .entry_err(entry_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Counting high cycles also catches strobes that stay up too long
    always @(negedge CLOCK_50) begin
        if (pattern_valid) pv_cnt++;
        if (entry_err) err_cnt++;
    end

    function automatic logic [23:0] work_m();
        logic [23:0] w = 24'hFFFFFF;
        foreach (q[i]) w[23 - 4*i -: 4] = q[i];
        return w;
    endfunction

    task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [23:0] ev = exp_pat;
        if (q.size() > 0) begin
            ev = work_m();
            ev[23 - 4*q.size() -: 4] = digit_in;
        end
        chk({tag, ".cursor"}, 24'(cursor), 24'(q.size()));
        chk({tag, ".busy"}, 24'(busy), 24'(q.size() > 0));
        chk({tag, ".edit_view"}, edit_view, ev);
        chk({tag, ".pattern"}, pattern, exp_pat);
        chk({tag, ".pv_count"}, 24'(pv_cnt), 24'(exp_pv));
        chk({tag, ".err_count"}, 24'(err_cnt), 24'(exp_err));
    endtask

    task automatic press(bit clr, bit ent, logic [3:0] d, int hold);
        @(negedge CLOCK_50);
        digit_in = d;
        if (clr) key_clear_n = 1'b0;
        if (ent) key_enter_n = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        key_clear_n = 1'b1;
        key_enter_n = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        if (clr) q.delete();
        else if (ent && d inside {[4'hA:4'hE]}) exp_err++;
        else if (ent) begin
            q.push_back(d);
            if (q.size() == 6) begin
                exp_pat = work_m();
                exp_pv++;
                q.delete();
            end
        end
    endtask

    task automatic glitch(logic [3:0] d);
        @(negedge CLOCK_50);
        digit_in = d;
        key_enter_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        key_enter_n = 1'b1;
        repeat (5) @(negedge CLOCK_50);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        check_all("reset");
        for (int i = 1; i <= 6; i++) press(1'b0, 1'b1, 4'(i), 8);
        check_all("full_entry");
        chk("full_pattern", pattern, 24'h123456);
        repeat (3) glitch(4'd7);
        check_all("bounce");
        press(1'b0, 1'b1, 4'd7, 10);
        check_all("bounce_commit");
        press(1'b0, 1'b1, 4'd3, 8);
        press(1'b0, 1'b1, 4'hA, 8);
        check_all("illegal");
        chk("illegal_cursor", 24'(cursor), 24'd2);
        press(1'b1, 1'b0, 4'd0, 8);
        press(1'b0, 1'b1, 4'd9, 8);
        press(1'b0, 1'b1, 4'd8, 8);
        press(1'b0, 1'b1, 4'd7, 8);
        press(1'b1, 1'b0, 4'd7, 8);
        check_all("clear_mid");
        press(1'b0, 1'b1, 4'd5, 8);
        press(1'b1, 1'b1, 4'hB, 8);
        check_all("clear_and_enter");
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            int v = $urandom_range(0, 10);
            if (r == 0) press(1'b1, 1'b0, 4'd0, 8);
            else if (r == 1) glitch(4'($urandom_range(0, 9)));
            else if (r == 2) press(1'b0, 1'b1, 4'($urandom_range(10, 14)), 8);
            else press(1'b0, 1'b1, (v == 10) ? 4'hF : 4'(v), 8);
            check_all("random");
        end
        press(1'b1, 1'b0, 4'd0, 8);
        press(1'b0, 1'b1, 4'd2, 8);
        check_all("timeout_pre");
        repeat (100) @(negedge CLOCK_50);
`ifdef ENTRY_TIMEOUT_EN
        q.delete();
`endif
        check_all("timeout");
        press(1'b1, 1'b0, 4'd0, 8);
        press(1'b0, 1'b1, 4'd4, 8);
        press(1'b0, 1'b1, 4'd6, 8);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        q.delete();
        exp_pat = 24'h085FFF;
        check_all("reset_in_entry");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
